// File: rtl/fft_bfly_seq.sv
// Radix-2 FFT stage butterfly sequencer: issues W*B requests to the twiddle
// multiplier, parks leg A in a FIFO and emits A+WB / A-WB as results return.
module fft_bfly_seq #(
   parameter int SIZE_DATA_FI  = 3,
   parameter int STAGE         = 0,
   parameter int DATA_FFT_SIZE = 16,
   parameter int RES_W         = 17,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_FFT_SIZE-1:0] in_a_i,
   input  logic [DATA_FFT_SIZE-1:0] in_a_q,
   input  logic [DATA_FFT_SIZE-1:0] in_b_i,
   input  logic [DATA_FFT_SIZE-1:0] in_b_q,
   output logic                     mult_en,
   output logic [DATA_FFT_SIZE-1:0] mult_data_i,
   output logic [DATA_FFT_SIZE-1:0] mult_data_q,
   output logic [15:0]              mult_fi_deg,
   input  logic [RES_W-1:0]         mult_res_i,
   input  logic [RES_W-1:0]         mult_res_q,
   input  logic                     mult_valid,
   output logic                     out_valid,
   output logic [RES_W:0]           out_top_i,
   output logic [RES_W:0]           out_top_q,
   output logic [RES_W:0]           out_bot_i,
   output logic [RES_W:0]           out_bot_q,
   output logic                     out_last,
   output logic                     err
);

   localparam int TW = SIZE_DATA_FI - 1;
   localparam int DW = DATA_FFT_SIZE;
   localparam int OW = RES_W + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SH = SIZE_DATA_FI - 1 - STAGE;
   localparam logic [TW-1:0] STG_MASK = TW'((1 << STAGE) - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef logic [2*DW:0] entry_t;

   entry_t          fifo_mem [FIFO_DEPTH];
   entry_t          head;

   logic [TW-1:0]   pair_cnt_q, pair_cnt_d;
   logic [TW-1:0]   tw_k;
   logic [CW-1:0]   outst_q, outst_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            accept, pop, spur;

   logic            mult_en_q;
   logic [DW-1:0]   mult_data_i_q, mult_data_q_q;
   logic [TW-1:0]   fi_deg_q;
   logic            out_valid_q, out_last_q, err_q;
   logic [OW-1:0]   top_i_q, top_q_q, bot_i_q, bot_q_q;
   logic [OW-1:0]   top_i_d, top_q_d, bot_i_d, bot_q_d;
   logic [OW-1:0]   a_i_x, a_q_x, r_i_x, r_q_x;

   // FIFO occupancy always equals the outstanding count, so it doubles as the fill level.
   assign in_ready = (outst_q < DEPTH_C);

   always_comb begin
      accept     = in_valid & in_ready;
      pop        = mult_valid & (outst_q != '0);
      spur       = mult_valid & (outst_q == '0);
      pair_cnt_d = pair_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      outst_d    = outst_q;
      if (accept) begin
         pair_cnt_d = pair_cnt_q + TW'(1);
         wr_ptr_d   = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({accept, pop})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_comb begin
      tw_k    = (pair_cnt_q & STG_MASK) << SH;
      head    = fifo_mem[rd_ptr_q];
      a_i_x   = {{(OW-DW){head[2*DW-1]}}, head[2*DW-1:DW]};
      a_q_x   = {{(OW-DW){head[DW-1]}}, head[DW-1:0]};
      r_i_x   = {mult_res_i[RES_W-1], mult_res_i};
      r_q_x   = {mult_res_q[RES_W-1], mult_res_q};
      top_i_d = a_i_x + r_i_x;
      top_q_d = a_q_x + r_q_x;
      bot_i_d = a_i_x - r_i_x;
      bot_q_d = a_q_x - r_q_x;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_mem[wr_ptr_q] <= {(pair_cnt_q == '1), in_a_i, in_a_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_cnt_q    <= '0;
         outst_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         mult_en_q     <= 1'b0;
         mult_data_i_q <= '0;
         mult_data_q_q <= '0;
         fi_deg_q      <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         top_i_q       <= '0;
         top_q_q       <= '0;
         bot_i_q       <= '0;
         bot_q_q       <= '0;
         err_q         <= 1'b0;
      end else begin
         pair_cnt_q  <= pair_cnt_d;
         outst_q     <= outst_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mult_en_q   <= accept;
         out_valid_q <= pop;
         err_q       <= err_q | spur;
         if (accept) begin
            mult_data_i_q <= in_b_i;
            mult_data_q_q <= in_b_q;
            fi_deg_q      <= tw_k;
         end
         if (pop) begin
            top_i_q    <= top_i_d;
            top_q_q    <= top_q_d;
            bot_i_q    <= bot_i_d;
            bot_q_q    <= bot_q_d;
            out_last_q <= head[2*DW];
         end
      end
   end

   assign mult_en     = mult_en_q;
   assign mult_data_i = mult_data_i_q;
   assign mult_data_q = mult_data_q_q;
   assign mult_fi_deg = {{(16-TW){1'b0}}, fi_deg_q};
   assign out_valid   = out_valid_q;
   assign out_top_i   = top_i_q;
   assign out_top_q   = top_q_q;
   assign out_bot_i   = bot_i_q;
   assign out_bot_q   = bot_q_q;
   assign out_last    = out_last_q;
   assign err         = err_q;

endmodule

// File: tb/tb_fft_bfly_seq.sv
// Scoreboard bench for fft_bfly_seq: three instances (STAGE 0/1/2) share stimulus
// and a behavioural multiplier; expectations are queued at accept time.
module tb_fft_bfly_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_a_i, in_a_q, in_b_i, in_b_q;
   logic [16:0] mult_res_i, mult_res_q;
   logic        mult_valid;

   logic        in_ready  [3];
   logic        mult_en   [3];
   logic [15:0] md_i      [3];
   logic [15:0] md_q      [3];
   logic [15:0] fi_deg    [3];
   logic        out_valid [3];
   logic [17:0] top_i     [3];
   logic [17:0] top_q     [3];
   logic [17:0] bot_i     [3];
   logic [17:0] bot_q     [3];
   logic        out_last  [3];
   logic        err       [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fft_bfly_seq #(
         .SIZE_DATA_FI (3),
         .STAGE        (g),
         .DATA_FFT_SIZE(16),
         .RES_W        (17),
         .FIFO_DEPTH   (4)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid),
         .in_ready   (in_ready[g]),
         .in_a_i     (in_a_i),
         .in_a_q     (in_a_q),
         .in_b_i     (in_b_i),
         .in_b_q     (in_b_q),
         .mult_en    (mult_en[g]),
         .mult_data_i(md_i[g]),
         .mult_data_q(md_q[g]),
         .mult_fi_deg(fi_deg[g]),
         .mult_res_i (mult_res_i),
         .mult_res_q (mult_res_q),
         .mult_valid (mult_valid),
         .out_valid  (out_valid[g]),
         .out_top_i  (top_i[g]),
         .out_top_q  (top_q[g]),
         .out_bot_i  (bot_i[g]),
         .out_bot_q  (bot_q[g]),
         .out_last   (out_last[g]),
         .err        (err[g])
      );
   end

   typedef struct { int ti; int tq; int bi; int bq; int last; } out_t;
   typedef struct { int k0; int k1; int k2; int bi; int bq; } req_t;
   typedef struct { int due; int ri; int rq; } pend_t;
   typedef struct { int ri; int rq; } res_t;

   out_t  exp_q  [$];
   req_t  req_q  [$];
   res_t  res_q  [$];
   pend_t pend_q [$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int lat    = 4;
   int pcnt   = 0;
   bit force_spur = 0;

   // Hand-derived twiddle indices for NFFT=8 and last flags, indexed by pair number mod 4.
   int K1T   [4] = '{0, 2, 0, 2};
   int K2T   [4] = '{0, 1, 2, 3};
   int LASTT [4] = '{0, 0, 0, 1};

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Behavioural multiplier: returns the queued result lat cycles after each request.
   always @(negedge clk) begin
      pend_t p;
      res_t  r;
      mult_valid = 1'b0;
      mult_res_i = '0;
      mult_res_q = '0;
      if (mult_en[2]) begin
         if (res_q.size() == 0) chk("model_req_without_result", 1, 0);
         else begin
            r = res_q.pop_front();
            pend_q.push_back('{cyc + lat, r.ri, r.rq});
         end
      end
      if (force_spur) begin
         force_spur = 0;
         mult_valid = 1'b1;
      end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         p = pend_q.pop_front();
         mult_valid = 1'b1;
         mult_res_i = 17'(p.ri);
         mult_res_q = 17'(p.rq);
      end
   end

   always @(negedge clk) begin
      req_t q;
      if (mult_en[2]) begin
         if (req_q.size() == 0) chk("unexpected_mult_en", 1, 0);
         else begin
            q = req_q.pop_front();
            for (int g = 0; g < 3; g++) begin
               chk("mult_en_sync", int'(mult_en[g]), 1);
               chk("mult_data_i", int'($signed(md_i[g])), q.bi);
               chk("mult_data_q", int'($signed(md_q[g])), q.bq);
            end
            chk("fi_deg_stage0", int'(fi_deg[0]), q.k0);
            chk("fi_deg_stage1", int'(fi_deg[1]), q.k1);
            chk("fi_deg_stage2", int'(fi_deg[2]), q.k2);
         end
      end
   end

   always @(negedge clk) begin
      out_t e;
      if (out_valid[2]) begin
         if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
         else begin
            e = exp_q.pop_front();
            for (int g = 0; g < 3; g++) begin
               chk("out_valid_sync", int'(out_valid[g]), 1);
               chk("out_top_i", int'($signed(top_i[g])), e.ti);
               chk("out_top_q", int'($signed(top_q[g])), e.tq);
               chk("out_bot_i", int'($signed(bot_i[g])), e.bi);
               chk("out_bot_q", int'($signed(bot_q[g])), e.bq);
               chk("out_last",  int'(out_last[g]), e.last);
            end
         end
      end
   end

   task automatic send(input int ai, input int aq, input int bi, input int bq,
                       input int ri, input int rq, input int ti, input int tq,
                       input int boti, input int botq, output int waited);
      in_a_i   = 16'(ai);
      in_a_q   = 16'(aq);
      in_b_i   = 16'(bi);
      in_b_q   = 16'(bq);
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready[2] && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (waited >= 100) chk("accept_timeout", waited, 0);
      res_q.push_back('{ri, rq});
      exp_q.push_back('{ti, tq, boti, botq, LASTT[pcnt % 4]});
      req_q.push_back('{0, K1T[pcnt % 4], K2T[pcnt % 4], bi, bq});
      pcnt++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_within_budget", int'(n < 300), 1);
      @(negedge clk);
   endtask

   task automatic check_reset_values();
      for (int g = 0; g < 3; g++) begin
         chk("rst_in_ready",  int'(in_ready[g]), 1);
         chk("rst_mult_en",   int'(mult_en[g]), 0);
         chk("rst_mult_data", int'({md_i[g], md_q[g]}), 0);
         chk("rst_fi_deg",    int'(fi_deg[g]), 0);
         chk("rst_out_valid", int'(out_valid[g]), 0);
         chk("rst_out_top",   int'(top_i[g] | top_q[g]), 0);
         chk("rst_out_bot",   int'(bot_i[g] | bot_q[g]), 0);
         chk("rst_out_last",  int'(out_last[g]), 0);
         chk("rst_err",       int'(err[g]), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int w, n, en_at;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_a_i   = '0;
      in_a_q   = '0;
      in_b_i   = '0;
      in_b_q   = '0;
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single pair, identity multiplier, latency 4
      send(100, 20, 30, -5, 30, -5, 130, 15, 70, 25, w);
      n = 0;
      en_at = -1;
      while (!out_valid[2] && n < 30) begin
         @(negedge clk);
         n++;
         if (mult_en[2] && en_at < 0) en_at = n;
      end
      chk("mult_en_latency", en_at, 1);
      chk("out_valid_latency", n, 6);
      drain();

      // Reset mid-stream with two requests in flight
      @(posedge clk);
      #1;
      send(1, 2, 3, 4, 3, 4, 4, 6, -2, -2, w);
      send(5, 6, 7, 8, 7, 8, 12, 14, -2, -2, w);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_values();
      exp_q.delete();
      pcnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ready_after_release", int'(in_ready[2]), 1);
      n = 0;
      while (pend_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++) chk("err_after_inflight", int'(err[g]), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) chk("err_cleared_by_reset", int'(err[g]), 0);

      // Index sequencing: 5 pairs back-to-back
      for (int i = 1; i <= 5; i++)
         send(10 * i, -i, i, 2 * i, i, 2 * i, 11 * i, i, 9 * i, -3 * i, w);
      drain();

      // Backpressure: latency 10, 8 pairs offered continuously
      lat = 10;
      for (int i = 0; i < 8; i++) begin
         send(1000 + i, -1000 - i, 7 * i, -3 * i, 7 * i, -3 * i,
              1000 + 8 * i, -1000 - 4 * i, 1000 - 6 * i, -1000 + 2 * i, w);
         if (i < 4) chk("bp_no_wait", w, 0);
         if (i == 3) chk("bp_ready_low_when_full", int'(in_ready[2]), 0);
         if (i == 4) chk("bp_fifth_waited", int'(w > 0), 1);
      end
      drain();

      // Simultaneous accept and result at outstanding = depth-1 (latency 2)
      lat = 2;
      for (int i = 0; i < 6; i++) begin
         send(-i, i, 100, -100, 100, -100, 100 - i, i - 100, -100 - i, 100 + i, w);
         chk("simul_no_wait", w, 0);
         chk("simul_ready_high", int'(in_ready[2]), 1);
      end
      drain();

      // Extremes at RES_W=17
      lat = 4;
      send(-32768, -32768, 0, 0, 65535, -65536, 32767, -98304, -98303, 32768, w);
      drain();

      // Spurious result with nothing outstanding
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) chk("err_before_spur", int'(err[g]), 0);
      force_spur = 1;
      @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) chk("err_sticky", int'(err[g]), 1);
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("requests_consumed", req_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
